// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared types, default sizes and helper functions for the radix-2 DIT FFT
// datapath blocks.
//   twiddle_state_t : state encoding of the twiddle sequencer
//   N, TW_MAX       : point count and full-scale twiddle magnitude for the
//                     default build (LOG2N = 5, COEF_W = 16)
//   fft_points()    : 2**log2n, for parameterised modules
//   tw_max()        : 2**(coef_w-1)-1, for parameterised modules
//   tw_index()      : twiddle index k for stage s, butterfly b
// -----------------------------------------------------------------------------
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } twiddle_state_t;

    localparam int unsigned DEF_LOG2N  = 5;
    localparam int unsigned DEF_COEF_W = 16;

    localparam int unsigned N      = 2 ** DEF_LOG2N;
    localparam int unsigned TW_MAX = 2 ** (DEF_COEF_W - 1) - 1;

    function automatic int unsigned fft_points(int unsigned log2n);
        return 32'd1 << log2n;
    endfunction

    function automatic int unsigned tw_max(int unsigned coef_w);
        return (32'd1 << (coef_w - 32'd1)) - 32'd1;
    endfunction

    // k = (b mod 2^s) << (log2n-1-s); always below N/2 for legal s.
    function automatic int unsigned tw_index(int unsigned s, int unsigned b,
                                             int unsigned log2n);
        int unsigned mask;
        mask = (32'd1 << s) - 32'd1;
        return (b & mask) << (log2n - 32'd1 - s);
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// -----------------------------------------------------------------------------
// twiddle_rom
// Quarter-to-half-circle twiddle table with N/2 entries, combinational read.
//   C[k] = round(cos(2*pi*k/N) * TW_MAX)
//   S[k] = round(sin(2*pi*k/N) * TW_MAX)   (S[k] >= 0 for 0 <= k < N/2)
// The table is computed at elaboration by a constant function; the caller
// registers the read data.
// Ports:
//   k_i   : table address k (LOG2N-1 bits)
//   cos_o : C[k], signed COEF_W
//   sin_o : S[k], signed COEF_W
// -----------------------------------------------------------------------------
module twiddle_rom
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N  = DEF_LOG2N,
    parameter int unsigned COEF_W = DEF_COEF_W
) (
    input  logic        [LOG2N-2:0]  k_i,
    output logic signed [COEF_W-1:0] cos_o,
    output logic signed [COEF_W-1:0] sin_o
);

    localparam int unsigned NPTS = fft_points(LOG2N);
    localparam int unsigned HALF = NPTS / 2;
    localparam int unsigned MAG  = tw_max(COEF_W);

    // Round half away from zero, then scale to the coefficient width.
    function automatic logic signed [COEF_W-1:0] rom_val(int unsigned k, bit want_sin);
        real theta;
        real v;
        int  r;
        theta = 2.0 * 3.14159265358979323846 * $itor(k) / $itor(NPTS);
        if (want_sin) begin
            v = $sin(theta) * $itor(MAG);
        end else begin
            v = $cos(theta) * $itor(MAG);
        end
        if (v >= 0.0) begin
            r = $rtoi(v + 0.5);
        end else begin
            r = -$rtoi(0.5 - v);
        end
        return COEF_W'(r);
    endfunction

    logic signed [COEF_W-1:0] cos_tab [HALF];
    logic signed [COEF_W-1:0] sin_tab [HALF];

    for (genvar g = 0; g < HALF; g++) begin : g_rom
        localparam logic signed [COEF_W-1:0] CV = rom_val(g, 1'b0);
        localparam logic signed [COEF_W-1:0] SV = rom_val(g, 1'b1);
        assign cos_tab[g] = CV;
        assign sin_tab[g] = SV;
    end

    assign cos_o = cos_tab[k_i];
    assign sin_o = sin_tab[k_i];

endmodule

// File: rtl/twiddle_gen.sv
// -----------------------------------------------------------------------------
// twiddle_gen
// Twiddle-factor sequencer for an N-point radix-2 DIT FFT. A start pulse walks
// every stage s and butterfly b, emitting W = C[k] -/+ j*S[k] per butterfly on
// a valid/ready stream (forward uses -S, inverse conjugates to +S).
// Ports:
//   clk           : clock, rising edge
//   reset         : synchronous, active-low reset
//   e_start       : start pulse, honoured only in IDLE
//   inv           : 0 forward / 1 inverse, sampled with e_start
//   out_valid     : twiddle word valid
//   out_ready     : consumer accepts the word
//   tw_re, tw_im  : real / imaginary part of W
//   tw_idx        : twiddle index k
//   stage, bfly   : stage s and butterfly b of the presented word
//   last_in_stage : word is the last butterfly of its stage
//   busy          : sequencer running
//   done          : one-cycle pulse after the final word
// All outputs are registered and coherent with out_valid.
// -----------------------------------------------------------------------------
module twiddle_gen
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N  = DEF_LOG2N,
    parameter int unsigned COEF_W = DEF_COEF_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       e_start,
    input  logic                       inv,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [COEF_W-1:0]   tw_re,
    output logic signed [COEF_W-1:0]   tw_im,
    output logic [LOG2N-2:0]           tw_idx,
    output logic [$clog2(LOG2N)-1:0]   stage,
    output logic [LOG2N-2:0]           bfly,
    output logic                       last_in_stage,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned HALF = fft_points(LOG2N) / 2;
    localparam int unsigned KW   = LOG2N - 1;
    localparam int unsigned SW   = $clog2(LOG2N);

    if (LOG2N < 3 || LOG2N > 12) begin : g_bad_log2n
        $error("twiddle_gen: LOG2N must be in 3..12");
    end

    twiddle_state_t           state_q;
    logic                     inv_q;
    logic [SW-1:0]            s_q;
    logic [KW-1:0]            b_q;
    logic                     out_valid_q;
    logic signed [COEF_W-1:0] tw_re_q;
    logic signed [COEF_W-1:0] tw_im_q;
    logic [KW-1:0]            tw_idx_q;
    logic                     last_q;
    logic                     busy_q;
    logic                     done_q;

    logic [SW-1:0]            s_d;
    logic [KW-1:0]            b_d;
    logic [KW-1:0]            k_d;
    logic signed [COEF_W-1:0] rom_cos;
    logic signed [COEF_W-1:0] rom_sin;
    logic signed [COEF_W-1:0] im_d;
    logic                     inv_sel;
    logic                     xfer;
    logic                     final_word;
    logic                     load;

    // Next word is looked up from the counters it will carry, so the ROM read
    // lands in the output register in the same edge as the counter update.
    always_comb begin
        xfer       = out_valid_q && out_ready;
        final_word = (s_q == SW'(LOG2N - 1)) && (b_q == KW'(HALF - 1));
        load       = 1'b0;
        s_d        = s_q;
        b_d        = b_q;

        if (state_q == IDLE) begin
            s_d  = '0;
            b_d  = '0;
            load = e_start;
        end else if (state_q == RUN && xfer && !final_word) begin
            load = 1'b1;
            if (b_q == KW'(HALF - 1)) begin
                b_d = '0;
                s_d = s_q + SW'(1);
            end else begin
                b_d = b_q + KW'(1);
            end
        end

        k_d = KW'(tw_index(32'(s_d), 32'(b_d), LOG2N));

        // On the start edge inv_q has not been captured yet.
        inv_sel = (state_q == IDLE) ? inv : inv_q;
        im_d    = inv_sel ? rom_sin : -rom_sin;
    end

    twiddle_rom #(
        .LOG2N  (LOG2N),
        .COEF_W (COEF_W)
    ) u_rom (
        .k_i   (k_d),
        .cos_o (rom_cos),
        .sin_o (rom_sin)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            inv_q       <= 1'b0;
            s_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            tw_re_q     <= '0;
            tw_im_q     <= '0;
            tw_idx_q    <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (e_start) begin
                        state_q <= RUN;
                        inv_q   <= inv;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (xfer && final_word) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b0;
                        last_q      <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase

            if (load) begin
                out_valid_q <= 1'b1;
                s_q         <= s_d;
                b_q         <= b_d;
                tw_idx_q    <= k_d;
                tw_re_q     <= rom_cos;
                tw_im_q     <= im_d;
                last_q      <= (b_d == KW'(HALF - 1));
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign tw_re         = tw_re_q;
    assign tw_im         = tw_im_q;
    assign tw_idx        = tw_idx_q;
    assign stage         = s_q;
    assign bfly          = b_q;
    assign last_in_stage = last_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_twiddle_gen.sv
// -----------------------------------------------------------------------------
// tb_twiddle_gen
// Randomised bench for twiddle_gen (LOG2N=5, COEF_W=16) against a trig-based
// reference table of the expected twiddle sequence.
// -----------------------------------------------------------------------------
module tb_twiddle_gen;

    localparam int unsigned LOG2N  = 5;
    localparam int unsigned COEF_W = 16;
    localparam int          NPTS   = 32;
    localparam int          HALF   = 16;
    localparam int          TOTAL  = 80;
    localparam int          MAG    = 32767;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     e_start;
    logic                     inv;
    logic                     out_ready;
    logic                     out_valid;
    logic signed [COEF_W-1:0] tw_re;
    logic signed [COEF_W-1:0] tw_im;
    logic [LOG2N-2:0]         tw_idx;
    logic [2:0]               stage;
    logic [LOG2N-2:0]         bfly;
    logic                     last_in_stage;
    logic                     busy;
    logic                     done;

    twiddle_gen #(
        .LOG2N  (LOG2N),
        .COEF_W (COEF_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .e_start       (e_start),
        .inv           (inv),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .tw_re         (tw_re),
        .tw_im         (tw_im),
        .tw_idx        (tw_idx),
        .stage         (stage),
        .bfly          (bfly),
        .last_in_stage (last_in_stage),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference sequence: every (s, b) pair in transfer order.
    int m_k     [TOTAL];
    int m_cos   [TOTAL];
    int m_sin   [TOTAL];
    int m_stage [TOTAL];
    int m_bfly  [TOTAL];
    int m_last  [TOTAL];

    function automatic int rnd(real v);
        return $rtoi($floor(v + 0.5));
    endfunction

    task automatic build_model();
        int  n;
        int  k;
        real th;
        n = 0;
        for (int s = 0; s < int'(LOG2N); s++) begin
            for (int b = 0; b < HALF; b++) begin
                k  = (b % (1 << s)) * (HALF >> s);
                th = 2.0 * 3.14159265358979323846 * k / NPTS;
                m_k[n]     = k;
                m_cos[n]   = rnd($cos(th) * MAG);
                m_sin[n]   = rnd($sin(th) * MAG);
                m_stage[n] = s;
                m_bfly[n]  = b;
                m_last[n]  = (b == HALF - 1) ? 1 : 0;
                n++;
            end
        end
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_re"}, int'(tw_re), 0);
        check({tag, "_im"}, int'(tw_im), 0);
        check({tag, "_idx"}, int'(tw_idx), 0);
        check({tag, "_stage"}, int'(stage), 0);
        check({tag, "_bfly"}, int'(bfly), 0);
        check({tag, "_last"}, int'(last_in_stage), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    // One transform. Inputs change and outputs are sampled on the falling edge.
    // abort_at >= 0 pulls reset (with a colliding e_start) after that many
    // transfers.
    task automatic run(input bit inv_m, input int ready_pct, input bit poke,
                       input int abort_at);
        int idx;
        int cyc;
        int lasts;
        int exp_im;
        idx   = 0;
        cyc   = 0;
        lasts = 0;
        @(negedge clk);
        e_start   = 1'b1;
        inv       = inv_m;
        out_ready = 1'b0;
        @(negedge clk);
        e_start = 1'b0;
        inv     = 1'($urandom_range(1));
        check("first_valid", int'(out_valid), 1);
        check("busy_run", int'(busy), 1);

        while (idx < TOTAL && cyc < 2000) begin
            if (abort_at >= 0 && idx == abort_at) begin
                reset   = 1'b0;
                e_start = 1'b1;
                @(negedge clk);
                reset   = 1'b1;
                e_start = 1'b0;
                expect_idle("abort");
                @(negedge clk);
                expect_idle("abort_hold");
                return;
            end
            if (!out_valid) begin
                check("no_bubble", int'(out_valid), 1);
                break;
            end
            // Whether stalled or not, the presented word is always word idx.
            exp_im = inv_m ? m_sin[idx] : -m_sin[idx];
            check("k", int'(tw_idx), m_k[idx]);
            check("re", int'(tw_re), m_cos[idx]);
            check("im", int'(tw_im), exp_im);
            check("stage", int'(stage), m_stage[idx]);
            check("bfly", int'(bfly), m_bfly[idx]);
            check("last", int'(last_in_stage), m_last[idx]);
            if (m_stage[idx] == 0) begin
                check("s0_re", int'(tw_re), MAG);
                check("s0_im", int'(tw_im), 0);
            end
            if (m_stage[idx] == 4 && m_bfly[idx] == 8) begin
                check("s4b8_k", int'(tw_idx), 8);
                check("s4b8_re", int'(tw_re), 0);
                check("s4b8_im", int'(tw_im), inv_m ? 32767 : -32767);
            end
            if (m_stage[idx] == 4 && m_bfly[idx] == 4) begin
                check("s4b4_k", int'(tw_idx), 4);
                check("s4b4_re", int'(tw_re), 23170);
                check("s4b4_im", int'(tw_im), inv_m ? 23170 : -23170);
            end

            out_ready = ($urandom_range(99) < ready_pct);
            if (poke && idx >= 20 && idx < 24) begin
                e_start = 1'b1;
                inv     = ~inv_m;
            end else begin
                e_start = 1'b0;
                inv     = 1'($urandom_range(1));
            end
            if (out_ready) begin
                if (last_in_stage) begin
                    lasts++;
                    check("last_pos", idx + 1, (lasts) * HALF);
                end
                idx++;
            end
            @(negedge clk);
            cyc++;
        end

        e_start = 1'b0;
        check("xfer_count", idx, TOTAL);
        check("last_count", lasts, 5);
        check("end_valid", int'(out_valid), 0);
        check("end_done_early", int'(done), 0);
        out_ready = 1'b0;
        @(negedge clk);
        check("done_pulse", int'(done), 1);
        check("done_busy", int'(busy), 0);
        check("done_valid", int'(out_valid), 0);
        @(negedge clk);
        check("done_clear", int'(done), 0);
        check("idle_busy", int'(busy), 0);
    endtask

    initial begin
        build_model();
        reset     = 1'b0;
        e_start   = 1'b1;
        inv       = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset   = 1'b1;
        e_start = 1'b0;
        inv     = 1'b0;
        expect_idle("reset");

        // Ready without valid in IDLE must do nothing.
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        expect_idle("idle_ready");
        out_ready = 1'b0;

        run(1'b0, 100, 1'b0, -1);
        run(1'b1, 100, 1'b0, -1);
        run(1'b0, 50, 1'b0, -1);
        run(1'b1, 50, 1'b1, -1);
        run(1'b0, 100, 1'b1, -1);
        run(1'b0, 70, 1'b0, 37);
        run(1'b0, 100, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
